// File: rtl/pc_sequencer.sv
// Registered program counter for simpleCPU with branch resolution and a
// circular return-address stack for CALL/RET. Displacements are PC-relative.
module pc_sequencer #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DISP_W    = 8,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  input  logic [3:0]        flags,
  output logic [ADDR_W-1:0] pc,
  output logic              is_jump,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic [2:0] {
    CLS_SEQ,
    CLS_B,
    CLS_BC,
    CLS_CALL,
    CLS_RET
  } instr_class_t;

  logic [1:0]              op1;
  logic [2:0]              op2;
  logic [2:0]              cond;
  logic signed [DISP_W-1:0] disp;
  logic [ADDR_W-1:0]       exd;
  logic [ADDR_W-1:0]       seq;
  logic [ADDR_W-1:0]       tgt;

  logic flag_z;
  logic flag_s;
  logic flag_c;
  logic flag_v;
  logic cond_true;

  instr_class_t      cls;
  logic [ADDR_W-1:0] next_pc;
  logic              taken;
  logic              do_push;
  logic              do_pop;
  logic              err;
  logic              commit;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  sp;
  logic [PTR_W-1:0]  sp_dec;
  logic [CNT_W-1:0]  count;

  assign op1  = instr[15:14];
  assign op2  = instr[13:11];
  assign cond = instr[10:8];
  assign disp = instr[DISP_W-1:0];

  // Signed cast sign-extends the displacement; sums wrap at ADDR_W bits.
  assign exd = ADDR_W'(disp);
  assign seq = pc + ADDR_W'(1);
  assign tgt = seq + exd;

  assign {flag_z, flag_s, flag_c, flag_v} = flags;

  assign sp_dec    = sp - PTR_W'(1);
  assign ras_empty = (count == '0);
  assign ras_full  = (count == CNT_W'(RAS_DEPTH));
  assign commit    = !stall && instr_valid;

  always_comb begin
    cls = CLS_SEQ;
    if (op1 == 2'b10) begin
      case (op2)
        3'b100:  cls = CLS_B;
        3'b111:  cls = CLS_BC;
        3'b101:  cls = CLS_CALL;
        3'b110:  cls = CLS_RET;
        default: cls = CLS_SEQ;
      endcase
    end
  end

  always_comb begin
    case (cond)
      3'b000:  cond_true = flag_z;
      3'b001:  cond_true = flag_s ^ flag_v;
      3'b010:  cond_true = flag_z | (flag_s ^ flag_v);
      3'b011:  cond_true = !flag_z;
      3'b100:  cond_true = flag_c;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = seq;
    taken   = 1'b0;
    do_push = 1'b0;
    do_pop  = 1'b0;
    err     = 1'b0;
    case (cls)
      CLS_B: begin
        next_pc = tgt;
        taken   = 1'b1;
      end
      CLS_BC: begin
        if (cond_true) begin
          next_pc = tgt;
          taken   = 1'b1;
        end
      end
      CLS_CALL: begin
        // A full stack still pushes, silently dropping the oldest entry.
        next_pc = tgt;
        taken   = 1'b1;
        do_push = 1'b1;
        err     = ras_full;
      end
      CLS_RET: begin
        if (ras_empty) begin
          err = 1'b1;
        end else begin
          next_pc = ras_mem[sp_dec];
          taken   = 1'b1;
          do_pop  = 1'b1;
        end
      end
      default: begin
        next_pc = seq;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= ADDR_W'(RESET_PC);
      is_jump <= 1'b0;
      ras_err <= 1'b0;
      sp      <= '0;
      count   <= '0;
    end else if (!stall) begin
      if (instr_valid) begin
        pc      <= next_pc;
        is_jump <= taken;
        ras_err <= err;
        if (do_push) begin
          sp <= sp + PTR_W'(1);
          if (!ras_full) begin
            count <= count + CNT_W'(1);
          end
        end else if (do_pop) begin
          sp    <= sp_dec;
          count <= count - CNT_W'(1);
        end
      end else begin
        is_jump <= 1'b0;
        ras_err <= 1'b0;
      end
    end
  end

  // Stack storage carries no reset; only sp and count define its contents.
  always_ff @(posedge clk) begin
    if (!rst && commit && do_push) begin
      ras_mem[sp] <= seq;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for flow, branches and
// CALL/RET, then hand-written overflow, stall, bubble and reset sequences.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        instr_valid;
  logic [15:0] instr;
  logic [3:0]  flags;
  logic [11:0] pc;
  logic        is_jump;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;

  int total;
  int bad;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        valid;
    logic [15:0] instr;
    logic [3:0]  flags;
    logic [11:0] exp_pc;
    logic        exp_jump;
    logic        exp_empty;
    logic        exp_full;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  pc_sequencer #(
    .ADDR_W   (12),
    .DISP_W   (8),
    .RAS_DEPTH(4),
    .RESET_PC (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .instr_valid(instr_valid),
    .instr      (instr),
    .flags      (flags),
    .pc         (pc),
    .is_jump    (is_jump),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .ras_err    (ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic r, input logic s, input logic v,
                        input logic [15:0] i, input logic [3:0] f,
                        input logic [11:0] p, input logic j, input logic e,
                        input logic fu, input logic er);
    vec_t t;
    t.rst = r; t.stall = s; t.valid = v; t.instr = i; t.flags = f;
    t.exp_pc = p; t.exp_jump = j; t.exp_empty = e; t.exp_full = fu;
    t.exp_err = er;
    vecs.push_back(t);
  endtask

  // Drive inputs, then let one rising edge pass and settle away from it.
  task automatic applyStimulus(input logic r, input logic s, input logic v,
                               input logic [15:0] i, input logic [3:0] f);
    rst = r; stall = s; instr_valid = v; instr = i; flags = f;
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(input string name, input string field,
                            input logic [11:0] got, input logic [11:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s %s got=%h want=%h", name, field, got, want);
    end
  endtask

  task automatic checkOutput(input string name, input logic [11:0] p,
                             input logic j, input logic e, input logic fu,
                             input logic er);
    checkField(name, "pc", pc, p);
    checkField(name, "is_jump", {11'b0, is_jump}, {11'b0, j});
    checkField(name, "ras_empty", {11'b0, ras_empty}, {11'b0, e});
    checkField(name, "ras_full", {11'b0, ras_full}, {11'b0, fu});
    checkField(name, "ras_err", {11'b0, ras_err}, {11'b0, er});
  endtask

  task automatic step(input string name, input logic r, input logic s,
                      input logic v, input logic [15:0] i, input logic [3:0] f,
                      input logic [11:0] p, input logic j, input logic e,
                      input logic fu, input logic er);
    applyStimulus(r, s, v, i, f);
    checkOutput(name, p, j, e, fu, er);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; stall = 1'b0; instr_valid = 1'b0; instr = '0; flags = '0;

    //     rst stall val instr     flags  pc      j  e  f  err
    addVec(1, 0, 1, 16'h0000, 4'h0, 12'h000, 0, 1, 0, 0);
    addVec(1, 0, 1, 16'h0000, 4'h0, 12'h000, 0, 1, 0, 0);
    addVec(0, 0, 1, 16'h0000, 4'h0, 12'h001, 0, 1, 0, 0);
    addVec(0, 0, 1, 16'h0000, 4'h0, 12'h002, 0, 1, 0, 0);
    addVec(0, 0, 1, 16'h0000, 4'h0, 12'h003, 0, 1, 0, 0);
    addVec(0, 0, 1, 16'hA0FA, 4'h0, 12'hFFE, 1, 1, 0, 0);
    addVec(0, 0, 1, 16'hA005, 4'h0, 12'h004, 1, 1, 0, 0);
    addVec(0, 0, 1, 16'h0000, 4'h0, 12'h005, 0, 1, 0, 0);
    addVec(0, 0, 1, 16'hA00A, 4'h0, 12'h010, 1, 1, 0, 0);
    addVec(0, 0, 1, 16'hA0FE, 4'h0, 12'h00F, 1, 1, 0, 0);
    addVec(0, 0, 1, 16'hA010, 4'h0, 12'h020, 1, 1, 0, 0);
    addVec(0, 0, 1, 16'hB903, 4'h4, 12'h024, 1, 1, 0, 0);
    addVec(0, 0, 1, 16'hA0FB, 4'h0, 12'h020, 1, 1, 0, 0);
    addVec(0, 0, 1, 16'hB903, 4'h5, 12'h021, 0, 1, 0, 0);
    addVec(0, 0, 1, 16'hBE03, 4'hF, 12'h022, 0, 1, 0, 0);
    addVec(0, 0, 1, 16'hB803, 4'h8, 12'h026, 1, 1, 0, 0);
    addVec(0, 0, 1, 16'hBB02, 4'h8, 12'h027, 0, 1, 0, 0);
    addVec(0, 0, 1, 16'hBC01, 4'h2, 12'h029, 1, 1, 0, 0);
    addVec(0, 0, 1, 16'hBA01, 4'h0, 12'h02A, 0, 1, 0, 0);
    addVec(0, 0, 1, 16'hBA01, 4'h1, 12'h02C, 1, 1, 0, 0);
    addVec(0, 0, 1, 16'hA0E3, 4'h0, 12'h010, 1, 1, 0, 0);
    addVec(0, 0, 1, 16'hA810, 4'h0, 12'h021, 1, 0, 0, 0);
    addVec(0, 0, 1, 16'hA804, 4'h0, 12'h026, 1, 0, 0, 0);
    addVec(0, 0, 1, 16'hB000, 4'h0, 12'h022, 1, 0, 0, 0);
    addVec(0, 0, 1, 16'hB000, 4'h0, 12'h011, 1, 1, 0, 0);
    addVec(0, 0, 1, 16'hB000, 4'h0, 12'h012, 0, 1, 0, 1);
    addVec(0, 0, 1, 16'h0000, 4'h0, 12'h013, 0, 1, 0, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].rst, vecs[k].stall, vecs[k].valid,
                    vecs[k].instr, vecs[k].flags);
      checkOutput($sformatf("vec%0d", k), vecs[k].exp_pc, vecs[k].exp_jump,
                  vecs[k].exp_empty, vecs[k].exp_full, vecs[k].exp_err);
    end

    // Five CALL +1 from 0x013: pushes 014,016,018,01A,01C; the fifth overflows.
    step("call1", 0, 0, 1, 16'hA801, 4'h0, 12'h015, 1, 0, 0, 0);
    step("call2", 0, 0, 1, 16'hA801, 4'h0, 12'h017, 1, 0, 0, 0);
    step("call3", 0, 0, 1, 16'hA801, 4'h0, 12'h019, 1, 0, 0, 0);
    step("call4", 0, 0, 1, 16'hA801, 4'h0, 12'h01B, 1, 0, 1, 0);
    step("call5_ovf", 0, 0, 1, 16'hA801, 4'h0, 12'h01D, 1, 0, 1, 1);
    step("ret1", 0, 0, 1, 16'hB000, 4'h0, 12'h01C, 1, 0, 0, 0);
    step("ret2", 0, 0, 1, 16'hB000, 4'h0, 12'h01A, 1, 0, 0, 0);
    step("ret3", 0, 0, 1, 16'hB000, 4'h0, 12'h018, 1, 0, 0, 0);
    step("ret4", 0, 0, 1, 16'hB000, 4'h0, 12'h016, 1, 1, 0, 0);
    step("ret5_unf", 0, 0, 1, 16'hB000, 4'h0, 12'h017, 0, 1, 0, 1);

    // Stall freezes a pending CALL and the is_jump level; release commits once.
    step("b_pre_stall", 0, 0, 1, 16'hA000, 4'h0, 12'h018, 1, 1, 0, 0);
    step("stall1", 0, 1, 1, 16'hA801, 4'h0, 12'h018, 1, 1, 0, 0);
    step("stall2", 0, 1, 1, 16'hA801, 4'h0, 12'h018, 1, 1, 0, 0);
    step("stall3", 0, 1, 1, 16'hA801, 4'h0, 12'h018, 1, 1, 0, 0);
    step("stall_release", 0, 0, 1, 16'hA801, 4'h0, 12'h01A, 1, 0, 0, 0);
    step("bubble", 0, 0, 0, 16'hA801, 4'h0, 12'h01A, 0, 0, 0, 0);
    step("ret_after_bubble", 0, 0, 1, 16'hB000, 4'h0, 12'h019, 1, 1, 0, 0);

    // Underflow pulse held through a stall, then cleared by a bubble.
    step("unf_again", 0, 0, 1, 16'hB000, 4'h0, 12'h01A, 0, 1, 0, 1);
    step("stall_err_hold", 0, 1, 1, 16'h0000, 4'h0, 12'h01A, 0, 1, 0, 1);
    step("bubble_err_clr", 0, 0, 0, 16'h0000, 4'h0, 12'h01A, 0, 1, 0, 0);

    // Reset in the middle of a CALL chain with an overflow pulse pending.
    step("chain1", 0, 0, 1, 16'hA801, 4'h0, 12'h01C, 1, 0, 0, 0);
    step("chain2", 0, 0, 1, 16'hA801, 4'h0, 12'h01E, 1, 0, 0, 0);
    step("chain3", 0, 0, 1, 16'hA801, 4'h0, 12'h020, 1, 0, 0, 0);
    step("chain4", 0, 0, 1, 16'hA801, 4'h0, 12'h022, 1, 0, 1, 0);
    step("chain5_ovf", 0, 0, 1, 16'hA801, 4'h0, 12'h024, 1, 0, 1, 1);
    step("mid_reset", 1, 1, 1, 16'hA801, 4'h0, 12'h000, 0, 1, 0, 0);
    step("ret_after_rst", 0, 0, 1, 16'hB000, 4'h0, 12'h001, 0, 1, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
